adbg_axi_seq: RTL and testbench

- AXI-clock-domain sequencer for the debug AXI master port.
- Accepts one burst command (read or write, start address, word size, word count) already transferred from the JTAG domain.
- Breaks the burst into single-beat AXI transactions, one per word, and streams words through valid/ready word interfaces.
- Aligns data and strobes to byte lanes, accumulates a sticky error flag and signals completion.

---
 rtl/adbg_axi_seq_pkg.sv | 27 ++
 rtl/adbg_axi_seq_if.sv | 39 +++
 rtl/adbg_axi_lane_align.sv | 39 +++
 rtl/adbg_axi_seq.sv | 194 +++++++++++++++++++
 tb/tb_adbg_axi_seq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adbg_axi_seq_pkg.sv
// Shared types and constants for the debug AXI sequencer.
// Contents: FSM state enum, word-size encodings, the OKAY response code
// and bytes_of(), which turns a size code into a byte count.
package adbg_axi_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WR_XFER,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RD_PUSH
   } state_t;

   localparam logic [1:0] SIZE_1B = 2'd0;
   localparam logic [1:0] SIZE_2B = 2'd1;
   localparam logic [1:0] SIZE_4B = 2'd2;
   localparam logic [1:0] SIZE_8B = 2'd3;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   function automatic logic [3:0] bytes_of(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/adbg_axi_seq_if.sv
// Single-beat AXI master bus used by the debug sequencer (AW/W/B/AR/R).
// Ports: the master modport drives the valids, addresses, sizes, write data/strobe and b/r ready.
// The slave modport drives the ready signals, the B/R responses and the read data.
interface adbg_axi_seq_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  aw_valid;
   logic                  aw_ready;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [2:0]            aw_size;
   logic                  w_valid;
   logic                  w_ready;
   logic [63:0]           w_data;
   logic [7:0]            w_strb;
   logic                  w_last;
   logic                  b_valid;
   logic                  b_ready;
   logic [1:0]            b_resp;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [2:0]            ar_size;
   logic                  r_valid;
   logic                  r_ready;
   logic [63:0]           r_data;
   logic [1:0]            r_resp;

   modport master (
      output aw_valid, aw_addr, aw_size, w_valid, w_data, w_strb, w_last,
             b_ready, ar_valid, ar_addr, ar_size, r_ready,
      input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );

   modport slave (
      input  aw_valid, aw_addr, aw_size, w_valid, w_data, w_strb, w_last,
             b_ready, ar_valid, ar_addr, ar_size, r_ready,
      output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );
endinterface

// File: rtl/adbg_axi_lane_align.sv
// Byte-lane alignment for 64-bit single beats; purely combinational, zero latency, no flow control.
// Ports: lane_i/size_i select the lanes. wdata_i is a right-aligned write word and wdata_o/strb_o are its lane-shifted form.
// rdata_raw_i is the raw bus read; rdata_o is the addressed bytes, right-aligned with the upper bytes zeroed.
module adbg_axi_lane_align
   import adbg_axi_seq_pkg::*;
(
   input  logic [2:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic [63:0] wdata_i,
   input  logic [63:0] rdata_raw_i,
   output logic [7:0]  strb_o,
   output logic [63:0] wdata_o,
   output logic [63:0] rdata_o
);
   logic [7:0]  byte_mask;
   logic [63:0] bit_mask;
   logic [5:0]  shift;

   always_comb begin
      byte_mask = 8'hFF;
      case (size_i)
         SIZE_1B: byte_mask = 8'h01;
         SIZE_2B: byte_mask = 8'h03;
         SIZE_4B: byte_mask = 8'h0F;
         SIZE_8B: byte_mask = 8'hFF;
         default: byte_mask = 8'hFF;
      endcase
   end

   for (genvar i = 0; i < 8; i++) begin : g_mask
      assign bit_mask[8*i +: 8] = {8{byte_mask[i]}};
   end

   assign shift   = {lane_i, 3'b000};
   // The address is aligned to the size, so the shifted mask never leaves the 8 lanes.
   assign strb_o  = byte_mask << lane_i;
   assign wdata_o = wdata_i << shift;
   assign rdata_o = (rdata_raw_i >> shift) & bit_mask;
endmodule

// File: rtl/adbg_axi_seq.sv
// Debug AXI sequencer: splits one burst command into single-beat AXI transactions, one word at a time.
// Ports: cmd_* accepts the command, wdata_*/rdata_* carry right-aligned words, done_o pulses at burst end
// and err_o is sticky until the next command. axi_master is the AXI bus with one transaction outstanding.
module adbg_axi_seq
   import adbg_axi_seq_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                      axi_aclk,
   input  logic                      axi_aresetn,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_we_i,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [1:0]                cmd_size_i,
   input  logic [15:0]               cmd_count_i,
   input  logic                      abort_i,
   input  logic                      wdata_valid_i,
   output logic                      wdata_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
   output logic                      rdata_valid_o,
   input  logic                      rdata_ready_i,
   output logic [AXI_DATA_WIDTH-1:0] rdata_o,
   output logic                      done_o,
   output logic                      err_o,
   adbg_axi_seq_if.master            axi_master
);
   state_t                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]               count_q, count_d;
   logic [1:0]                size_q, size_d;
   logic                      we_q, we_d;
   logic                      abort_q, abort_d;
   logic                      err_q, err_d;
   logic                      done_q, done_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic [AXI_DATA_WIDTH-1:0] wbuf_q, wbuf_d;
   logic [AXI_DATA_WIDTH-1:0] rbuf_q, rbuf_d;

   logic [AXI_ADDR_WIDTH-1:0] align_mask;
   logic                      word_end;
   logic                      aw_ok, w_ok;
   logic [63:0]               rd_extract;

   adbg_axi_lane_align u_align (
      .lane_i      (addr_q[2:0]),
      .size_i      (size_q),
      .wdata_i     (wbuf_q),
      .rdata_raw_i (axi_master.r_data),
      .strb_o      (axi_master.w_strb),
      .wdata_o     (axi_master.w_data),
      .rdata_o     (rd_extract)
   );

   // Commands are refused while reset is held, so every ready output reads 0 during reset.
   assign cmd_ready_o   = (state_q == ST_IDLE) && axi_aresetn;
   assign wdata_ready_o = (state_q == ST_WR_DATA);
   assign rdata_valid_o = (state_q == ST_RD_PUSH);
   assign rdata_o       = rbuf_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

   assign axi_master.aw_valid = (state_q == ST_WR_XFER) && !aw_done_q;
   assign axi_master.w_valid  = (state_q == ST_WR_XFER) && !w_done_q;
   assign axi_master.aw_addr  = addr_q;
   assign axi_master.aw_size  = {1'b0, size_q};
   assign axi_master.w_last   = 1'b1;
   assign axi_master.b_ready  = (state_q == ST_WR_RESP);
   assign axi_master.ar_valid = (state_q == ST_RD_ADDR);
   assign axi_master.ar_addr  = addr_q;
   assign axi_master.ar_size  = {1'b0, size_q};
   assign axi_master.r_ready  = (state_q == ST_RD_DATA);

   assign align_mask = AXI_ADDR_WIDTH'(bytes_of(cmd_size_i)) - AXI_ADDR_WIDTH'(1);
   assign aw_ok      = aw_done_q || (axi_master.aw_valid && axi_master.aw_ready);
   assign w_ok       = w_done_q  || (axi_master.w_valid  && axi_master.w_ready);

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         size_q    <= '0;
         we_q      <= 1'b0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         wbuf_q    <= '0;
         rbuf_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         size_q    <= size_d;
         we_q      <= we_d;
         abort_q   <= abort_d;
         err_q     <= err_d;
         done_q    <= done_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         wbuf_q    <= wbuf_d;
         rbuf_q    <= rbuf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      size_d    = size_q;
      we_d      = we_q;
      abort_d   = abort_q;
      err_d     = err_q;
      done_d    = 1'b0;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      wbuf_d    = wbuf_q;
      rbuf_d    = rbuf_q;
      word_end  = 1'b0;

      // Abort is remembered and only acted on at the next word boundary.
      if (state_q != ST_IDLE && abort_i) begin
         abort_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               we_d    = cmd_we_i;
               size_d  = cmd_size_i;
               count_d = cmd_count_i;
               // Misaligned starts are aligned down and flagged, but still run.
               addr_d  = cmd_addr_i & ~align_mask;
               err_d   = |(cmd_addr_i & align_mask);
               abort_d = 1'b0;
               state_d = cmd_we_i ? ST_WR_DATA : ST_RD_ADDR;
            end
         end
         ST_WR_DATA: begin
            if (wdata_valid_i) begin
               wbuf_d  = wdata_i;
               state_d = ST_WR_XFER;
            end
         end
         ST_WR_XFER: begin
            // AW and W complete independently; move on once both have gone.
            if (aw_ok && w_ok) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_WR_RESP;
            end else begin
               aw_done_d = aw_ok;
               w_done_d  = w_ok;
            end
         end
         ST_WR_RESP: begin
            if (axi_master.b_valid) begin
               if (axi_master.b_resp != RESP_OKAY) err_d = 1'b1;
               word_end = 1'b1;
            end
         end
         ST_RD_ADDR: begin
            if (axi_master.ar_ready) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (axi_master.r_valid) begin
               rbuf_d = AXI_DATA_WIDTH'(rd_extract);
               if (axi_master.r_resp != RESP_OKAY) err_d = 1'b1;
               state_d = ST_RD_PUSH;
            end
         end
         ST_RD_PUSH: begin
            if (rdata_ready_i) word_end = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (word_end) begin
         addr_d = addr_q + AXI_ADDR_WIDTH'(bytes_of(size_q));
         if (count_q == 16'd0 || abort_d) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
         end else begin
            count_d = count_q - 16'd1;
            state_d = we_q ? ST_WR_DATA : ST_RD_ADDR;
         end
      end
   end
endmodule

// File: tb/tb_adbg_axi_seq.sv
module tb_adbg_axi_seq;
   import adbg_axi_seq_pkg::*;

   logic        axi_aclk = 1'b0;
   logic        axi_aresetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [1:0]  cmd_size = '0;
   logic [15:0] cmd_count = '0;
   logic        abort = 1'b0;
   logic        wdata_valid = 1'b0;
   logic        wdata_ready;
   logic [63:0] wdata = '0;
   logic        rdata_valid;
   logic        rdata_ready = 1'b0;
   logic [63:0] rdata;
   logic        done;
   logic        err;

   adbg_axi_seq_if #(.ADDR_WIDTH(32)) axi_master();

   adbg_axi_seq #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) dut (
      .axi_aclk      (axi_aclk),
      .axi_aresetn   (axi_aresetn),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_we_i      (cmd_we),
      .cmd_addr_i    (cmd_addr),
      .cmd_size_i    (cmd_size),
      .cmd_count_i   (cmd_count),
      .abort_i       (abort),
      .wdata_valid_i (wdata_valid),
      .wdata_ready_o (wdata_ready),
      .wdata_i       (wdata),
      .rdata_valid_o (rdata_valid),
      .rdata_ready_i (rdata_ready),
      .rdata_o       (rdata),
      .done_o        (done),
      .err_o         (err),
      .axi_master    (axi_master)
   );

   always #5 axi_aclk = ~axi_aclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Scoreboard queues: filled when a test is planned, drained by the bus processes.
   logic [31:0] aw_q[$];
   logic [7:0]  ws_q[$];
   logic [63:0] wd_q[$];
   logic [63:0] wq[$];
   logic [1:0]  bresp_q[$];
   logic [31:0] ar_q[$];
   logic [63:0] rq[$];
   logic [1:0]  rresp_q[$];
   logic [63:0] rd_q[$];

   int       aw_delay = 0, w_delay = 0, ar_delay = 0, rd_delay = 0;
   logic [1:0] cur_size = 2'd0;
   bit       r_hold = 0;
   int       done_cnt = 0, rd_cnt = 0;
   logic     err_at_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] strb_of(input logic [31:0] a, input logic [1:0] s);
      logic [7:0] st = '0;
      for (int i = 0; i < (1 << s); i++) st[a[2:0] + i] = 1'b1;
      return st;
   endfunction

   function automatic logic [63:0] extract(input logic [63:0] raw, input logic [31:0] a,
                                           input logic [1:0] s);
      logic [63:0] r = '0;
      for (int i = 0; i < (1 << s); i++) r[8*i +: 8] = raw[8*(int'(a[2:0]) + i) +: 8];
      return r;
   endfunction

   task automatic plan_wr(input logic [31:0] a, input logic [1:0] s, input logic [63:0] word,
                          input logic [1:0] resp);
      aw_q.push_back(a);
      ws_q.push_back(strb_of(a, s));
      wd_q.push_back(word << (8 * a[2:0]));
      wq.push_back(word);
      bresp_q.push_back(resp);
   endtask

   task automatic plan_rd(input logic [31:0] a, input logic [1:0] s, input logic [63:0] raw,
                          input logic [1:0] resp);
      ar_q.push_back(a);
      rq.push_back(raw);
      rresp_q.push_back(resp);
      rd_q.push_back(extract(raw, a, s));
   endtask

   // AW slave: optional delay, checks hold, address, size and that valid drops after the handshake.
   initial begin
      int d;
      axi_master.aw_ready = 1'b0;
      forever begin
         @(negedge axi_aclk);
         if (axi_master.aw_valid) begin
            d = aw_delay;
            while (d > 0) begin
               @(negedge axi_aclk);
               d--;
               chk("aw_hold", axi_master.aw_valid, 1);
            end
            axi_master.aw_ready = 1'b1;
            chk("aw_expected", aw_q.size() > 0, 1);
            if (aw_q.size() > 0) chk("aw_addr", axi_master.aw_addr, aw_q.pop_front());
            chk("aw_size", axi_master.aw_size, {1'b0, cur_size});
            @(negedge axi_aclk);
            axi_master.aw_ready = 1'b0;
            chk("aw_drop", axi_master.aw_valid, 0);
         end
      end
   end

   // W slave.
   initial begin
      int d;
      axi_master.w_ready = 1'b0;
      forever begin
         @(negedge axi_aclk);
         if (axi_master.w_valid) begin
            d = w_delay;
            while (d > 0) begin
               @(negedge axi_aclk);
               d--;
               chk("w_hold", axi_master.w_valid, 1);
            end
            axi_master.w_ready = 1'b1;
            chk("w_expected", ws_q.size() > 0, 1);
            if (ws_q.size() > 0) begin
               chk("w_strb", axi_master.w_strb, ws_q.pop_front());
               chk("w_data", axi_master.w_data, wd_q.pop_front());
            end
            chk("w_last", axi_master.w_last, 1);
            @(negedge axi_aclk);
            axi_master.w_ready = 1'b0;
            chk("w_drop", axi_master.w_valid, 0);
         end
      end
   end

   // B slave.
   initial begin
      axi_master.b_valid = 1'b0;
      axi_master.b_resp  = RESP_OKAY;
      forever begin
         @(negedge axi_aclk);
         if (axi_master.b_ready) begin
            axi_master.b_valid = 1'b1;
            axi_master.b_resp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : RESP_OKAY;
            @(negedge axi_aclk);
            axi_master.b_valid = 1'b0;
         end
      end
   end

   // AR slave.
   initial begin
      int d;
      axi_master.ar_ready = 1'b0;
      forever begin
         @(negedge axi_aclk);
         if (axi_master.ar_valid) begin
            d = ar_delay;
            while (d > 0) begin
               @(negedge axi_aclk);
               d--;
               chk("ar_hold", axi_master.ar_valid, 1);
            end
            axi_master.ar_ready = 1'b1;
            chk("ar_expected", ar_q.size() > 0, 1);
            if (ar_q.size() > 0) chk("ar_addr", axi_master.ar_addr, ar_q.pop_front());
            chk("ar_size", axi_master.ar_size, {1'b0, cur_size});
            @(negedge axi_aclk);
            axi_master.ar_ready = 1'b0;
            chk("ar_drop", axi_master.ar_valid, 0);
         end
      end
   end

   // R slave.
   initial begin
      axi_master.r_valid = 1'b0;
      axi_master.r_data  = '0;
      axi_master.r_resp  = RESP_OKAY;
      forever begin
         @(negedge axi_aclk);
         if (axi_master.r_ready && !r_hold) begin
            chk("r_expected", rq.size() > 0, 1);
            axi_master.r_valid = 1'b1;
            axi_master.r_data  = (rq.size() > 0) ? rq.pop_front() : 64'h0;
            axi_master.r_resp  = (rresp_q.size() > 0) ? rresp_q.pop_front() : RESP_OKAY;
            @(negedge axi_aclk);
            axi_master.r_valid = 1'b0;
         end
      end
   end

   // Write-word producer.
   initial begin
      forever begin
         @(negedge axi_aclk);
         if (wdata_ready && wq.size() > 0) begin
            wdata_valid = 1'b1;
            wdata       = wq.pop_front();
            @(negedge axi_aclk);
            wdata_valid = 1'b0;
         end
      end
   end

   // Read-word consumer: optional delay with stability check, then compare against scoreboard.
   initial begin
      int d;
      logic [63:0] held;
      forever begin
         @(negedge axi_aclk);
         if (rdata_valid) begin
            held = rdata;
            d = rd_delay;
            while (d > 0) begin
               @(negedge axi_aclk);
               d--;
               chk("rdata_hold", {rdata_valid, rdata} == {1'b1, held}, 1);
            end
            rdata_ready = 1'b1;
            chk("rdata_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) chk("rdata", rdata, rd_q.pop_front());
            rd_cnt++;
            @(negedge axi_aclk);
            rdata_ready = 1'b0;
         end
      end
   end

   // Done pulse monitor.
   initial begin
      forever begin
         @(negedge axi_aclk);
         if (done) begin
            done_cnt++;
            err_at_done = err;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic we, input logic [31:0] a, input logic [1:0] s,
                           input logic [15:0] cnt);
      int t = 0;
      @(negedge axi_aclk);
      cur_size  = s;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_size  = s;
      cmd_count = cnt;
      cmd_valid = 1'b1;
      while (!cmd_ready && t < 50) begin
         @(negedge axi_aclk);
         t++;
      end
      chk("cmd_accept", cmd_ready, 1);
      @(negedge axi_aclk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input logic exp_err);
      int start = done_cnt;
      int t = 0;
      while (done_cnt == start && t < 3000) begin
         @(negedge axi_aclk);
         t++;
      end
      chk("done_seen", done_cnt != start, 1);
      repeat (4) @(negedge axi_aclk);
      chk("done_pulses", done_cnt - start, 1);
      chk("err_at_done", err_at_done, exp_err);
      chk("queues_drained", aw_q.size() + ws_q.size() + ar_q.size() + rd_q.size(), 0);
   endtask

   initial begin
      logic [31:0] a;
      logic [63:0] raw;
      int t;
      int start;

      // Reset state.
      repeat (3) @(negedge axi_aclk);
      chk("rst_outputs", {cmd_ready, axi_master.aw_valid, axi_master.w_valid, axi_master.b_ready,
                          axi_master.ar_valid, axi_master.r_ready, wdata_ready, rdata_valid,
                          done, err}, 0);
      chk("rst_rdata", rdata, 0);
      axi_aresetn = 1'b1;
      @(negedge axi_aclk);
      chk("idle_cmd_ready", cmd_ready, 1);

      // 1: four 4-byte writes from 0x1000.
      a = 32'h1000;
      for (int i = 0; i < 4; i++) begin
         plan_wr(a, 2'd2, 64'(32'h1111_1111 * (i + 1)), RESP_OKAY);
         a += 4;
      end
      send_cmd(1'b1, 32'h1000, 2'd2, 16'd3);
      wait_done(1'b0);
      chk("t1_err", err, 0);

      // 2: byte reads at 0x2003 and 0x2004.
      raw = {$urandom, $urandom};
      raw[31:24] = 8'hAA;
      plan_rd(32'h2003, 2'd0, raw, RESP_OKAY);
      raw = {$urandom, $urandom};
      raw[39:32] = 8'hBB;
      plan_rd(32'h2004, 2'd0, raw, RESP_OKAY);
      chk("t2_model_aa", rd_q[0], 64'hAA);
      chk("t2_model_bb", rd_q[1], 64'hBB);
      send_cmd(1'b0, 32'h2003, 2'd0, 16'd1);
      wait_done(1'b0);

      // 3: delayed AW, then delayed W.
      aw_delay = 3;
      plan_wr(32'h3000, 2'd3, {$urandom, $urandom}, RESP_OKAY);
      plan_wr(32'h3008, 2'd3, {$urandom, $urandom}, RESP_OKAY);
      send_cmd(1'b1, 32'h3000, 2'd3, 16'd1);
      wait_done(1'b0);
      aw_delay = 0;
      w_delay  = 3;
      plan_wr(32'h3104, 2'd1, 64'h0000_0000_0000_BEEF, RESP_OKAY);
      plan_wr(32'h3106, 2'd1, 64'h0000_0000_0000_CAFE, RESP_OKAY);
      send_cmd(1'b1, 32'h3104, 2'd1, 16'd1);
      wait_done(1'b0);
      w_delay = 0;

      // 4: three reads, the second returns SLVERR; slow consumer.
      rd_delay = 2;
      plan_rd(32'h4000, 2'd2, {$urandom, $urandom}, RESP_OKAY);
      plan_rd(32'h4004, 2'd2, {$urandom, $urandom}, 2'b10);
      plan_rd(32'h4008, 2'd2, {$urandom, $urandom}, RESP_OKAY);
      send_cmd(1'b0, 32'h4000, 2'd2, 16'd2);
      wait_done(1'b1);
      chk("t4_err_sticky", err, 1);
      rd_delay = 0;

      // 5a: 8-byte reads wrap the address space; accept clears err.
      plan_rd(32'hFFFF_FFF8, 2'd3, {$urandom, $urandom}, RESP_OKAY);
      plan_rd(32'h0000_0000, 2'd3, {$urandom, $urandom}, RESP_OKAY);
      send_cmd(1'b0, 32'hFFFF_FFF8, 2'd3, 16'd1);
      chk("t5_err_cleared", err, 0);
      wait_done(1'b0);

      // 5b: misaligned start is aligned down and flagged.
      plan_rd(32'h1000, 2'd2, {$urandom, $urandom}, RESP_OKAY);
      send_cmd(1'b0, 32'h1002, 2'd2, 16'd0);
      chk("t5_err_misalign", err, 1);
      wait_done(1'b1);

      // 6a: abort during the second of ten reads.
      ar_delay = 2;
      plan_rd(32'h5000, 2'd2, {$urandom, $urandom}, RESP_OKAY);
      plan_rd(32'h5004, 2'd2, {$urandom, $urandom}, RESP_OKAY);
      start = rd_cnt;
      send_cmd(1'b0, 32'h5000, 2'd2, 16'd9);
      t = 0;
      while (rd_cnt == start && t < 200) begin
         @(negedge axi_aclk);
         t++;
      end
      chk("t6_first_word", rd_cnt - start, 1);
      @(negedge axi_aclk);
      abort = 1'b1;
      @(negedge axi_aclk);
      abort = 1'b0;
      wait_done(1'b0);
      repeat (20) @(negedge axi_aclk);
      chk("t6_abort_words", rd_cnt - start, 2);
      chk("t6_no_more_ar", axi_master.ar_valid, 0);
      ar_delay = 0;

      // 6b: reset while waiting for read data.
      r_hold = 1;
      ar_q.push_back(32'h6000);
      send_cmd(1'b0, 32'h6000, 2'd2, 16'd3);
      t = 0;
      while (!axi_master.r_ready && t < 50) begin
         @(negedge axi_aclk);
         t++;
      end
      chk("t6_in_rd_data", axi_master.r_ready, 1);
      axi_aresetn = 1'b0;
      #1;
      chk("t6_rst_outputs", {cmd_ready, axi_master.aw_valid, axi_master.w_valid,
                             axi_master.b_ready, axi_master.ar_valid, axi_master.r_ready,
                             wdata_ready, rdata_valid, done, err}, 0);
      chk("t6_rst_rdata", rdata, 0);
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;
      r_hold = 0;
      #1;
      chk("t6_post_rst_ready", cmd_ready, 1);
      chk("t6_post_rst_idle", {axi_master.ar_valid, axi_master.r_ready, rdata_valid, done}, 0);

      // Recovery: one 2-byte read after reset.
      plan_rd(32'h7002, 2'd1, {$urandom, $urandom}, RESP_OKAY);
      send_cmd(1'b0, 32'h7002, 2'd1, 16'd0);
      wait_done(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
